// File: rtl/out_stream_tx_pkg.sv
// Shared widths and FSM encoding for the program-output transmitter.
package out_stream_tx_pkg;

    localparam int unsigned OUT_W = 3;
    localparam int unsigned ST_W  = 2;

    localparam logic [1:0] TX_IDLE     = 2'd0;
    localparam logic [1:0] TX_REQ      = 2'd1;
    localparam logic [1:0] TX_WAIT_LOW = 2'd2;
    localparam logic [1:0] TX_DONE     = 2'd3;

endpackage

// File: rtl/out_stream_tx_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/out_stream_tx.sv
// Buffers execute-stage output values and sends them off-chip over a
// four-phase req/ack handshake; flags end of program after the last ack.
module out_stream_tx
    import out_stream_tx_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [OUT_W-1:0]             out_data,
    input  logic                         out_valid,
    input  logic                         halt_ex,
    input  logic                         ext_ack,
    output logic [OUT_W-1:0]             tx_data,
    output logic                         tx_req,
    output logic                         tx_done,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Elaboration-time parameter sanity.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("out_stream_tx: DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("out_stream_tx: SYNC_STAGES must be >= 2");
    end

    logic                ack_s;
    logic [OUT_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [ST_W-1:0]     state;
    logic [ST_W-1:0]     state_nxt;
    logic [OUT_W-1:0]    tx_data_nxt;
    logic                tx_req_nxt;
    logic                tx_done_nxt;
    logic                fifo_empty_c;
    logic                fifo_full_c;
    logic                accept_c;
    logic                push_c;
    logic                pop_c;
    logic                drop_c;

    // Bring the reader's acknowledge into the clk domain.
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ext_ack),
        .q   (ack_s)
    );

    assign fifo_empty_c = (fifo_count == '0);
    assign fifo_full_c  = (fifo_count == CNT_W'(DEPTH));

    // Handshake FSM: request from IDLE, pop on ack, wait for ack release.
    always_comb begin
        state_nxt   = state;
        tx_data_nxt = tx_data;
        tx_req_nxt  = tx_req;
        tx_done_nxt = tx_done;
        pop_c       = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty_c) begin
                    tx_data_nxt = mem[rd_ptr];
                    tx_req_nxt  = 1'b1;
                    state_nxt   = TX_REQ;
                end else if (halt_ex && !out_valid) begin
                    // A value arriving alongside halt must still go out first.
                    tx_done_nxt = 1'b1;
                    state_nxt   = TX_DONE;
                end
            end
            TX_REQ: begin
                if (ack_s) begin
                    pop_c      = 1'b1;
                    tx_req_nxt = 1'b0;
                    state_nxt  = TX_WAIT_LOW;
                end
            end
            TX_WAIT_LOW: begin
                if (!ack_s) begin
                    state_nxt = TX_IDLE;
                end
            end
            TX_DONE: begin
                tx_req_nxt  = 1'b0;
                tx_done_nxt = 1'b1;
            end
            default: begin
                state_nxt  = TX_IDLE;
                tx_req_nxt = 1'b0;
            end
        endcase
    end

    // Push qualification; a pop in the same cycle frees a slot in a full FIFO.
    always_comb begin
        accept_c = out_valid && (state != TX_DONE);
        push_c   = accept_c && (!fifo_full_c || pop_c);
        drop_c   = accept_c && fifo_full_c && !pop_c;
    end

    // FSM state, handshake outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_data  <= '0;
            tx_req   <= 1'b0;
            tx_done  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_data  <= tx_data_nxt;
            tx_req   <= tx_req_nxt;
            tx_done  <= tx_done_nxt;
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= out_data;
        end
    end

endmodule

// File: tb/tb_out_stream_tx.sv
// Directed self-checking bench for out_stream_tx.
module tb_out_stream_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] out_data;
    logic       out_valid;
    logic       halt_ex;
    logic       ext_ack;
    logic [2:0] tx_data;
    logic       tx_req;
    logic       tx_done;
    logic       overflow;
    logic [4:0] fifo_count;

    int total = 0;
    int bad   = 0;

    out_stream_tx #(
        .DEPTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halt_ex    (halt_ex),
        .ext_ack    (ext_ack),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_done    (tx_done),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_valid = 1'b0;
        out_data  = 3'd0;
        halt_ex   = 1'b0;
        ext_ack   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [2:0] v);
        out_valid = 1'b1;
        out_data  = v;
        tick();
        out_valid = 1'b0;
    endtask

    // Acts as the external reader for one handshake.
    task automatic serve(input int delay, output logic [2:0] d, output bit ok);
        int n;
        ok = 1'b1;
        d  = 3'd0;
        n  = 0;
        while (tx_req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (tx_req !== 1'b1) ok = 1'b0;
        d = tx_data;
        repeat (delay) tick();
        ext_ack = 1'b1;
        n = 0;
        while (tx_req !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        if (tx_req !== 1'b0) ok = 1'b0;
        ext_ack = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (tx_done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_valid = 1'b0;
        out_data  = 3'd0;
        halt_ex   = 1'b0;
        ext_ack   = 1'b0;
        repeat (2) tick();
        total++; if (tx_req !== 1'b0)    begin bad++; $display("FAIL reset_tx_req got=%b exp=0", tx_req); end
        total++; if (tx_data !== 3'd0)   begin bad++; $display("FAIL reset_tx_data got=%0d exp=0", tx_data); end
        total++; if (tx_done !== 1'b0)   begin bad++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        repeat (10) tick();
        out_valid = 1'b1; out_data = 3'd5;      // cycle 10
        tick();                                  // cycle 11
        out_valid = 1'b0;
        total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL single_req_c11 got=%b exp=0", tx_req); end
        tick();                                  // cycle 12
        total++; if (tx_req !== 1'b1 || tx_data !== 3'd5) begin
            bad++; $display("FAIL single_req_c12 got req=%b data=%0d exp req=1 data=5", tx_req, tx_data);
        end
        repeat (8) tick();                       // cycle 20
        ext_ack = 1'b1;
        repeat (2) tick();                       // cycle 22
        total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL single_req_c22 got=%b exp=1", tx_req); end
        tick();                                  // cycle 23
        total++; if (tx_req !== 1'b0 || fifo_count !== 5'd0) begin
            bad++; $display("FAIL single_ack_c23 got req=%b cnt=%0d exp req=0 cnt=0", tx_req, fifo_count);
        end
        repeat (2) tick();                       // cycle 25
        ext_ack = 1'b0;
        halt_ex = 1'b1;
        repeat (3) tick();                       // cycle 28
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL single_done_c28 got=%b exp=0", tx_done); end
        tick();                                  // cycle 29
        total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL single_done_c29 got=%b exp=1", tx_done); end
    endtask

    task automatic test_burst();
        logic [2:0] vals [8];
        logic [2:0] d;
        bit         ok;
        logic [4:0] peak;
        vals = '{3'd2, 3'd4, 3'd1, 3'd5, 3'd7, 3'd5, 3'd0, 3'd3};
        do_reset();
        peak = 5'd0;
        for (int i = 0; i < 8; i++) begin
            out_valid = 1'b1; out_data = vals[i];
            tick();
            if (fifo_count > peak) peak = fifo_count;
        end
        out_valid = 1'b0;
        halt_ex   = 1'b1;
        total++; if (peak !== 5'd8) begin bad++; $display("FAIL burst_peak got=%0d exp=8", peak); end
        for (int i = 0; i < 8; i++) begin
            serve(10, d, ok);
            total++; if (!ok || d !== vals[i]) begin
                bad++; $display("FAIL burst_data[%0d] got=%0d ok=%0d exp=%0d", i, d, ok, vals[i]);
            end
        end
        wait_done();
        total++; if (tx_done !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL burst_end got done=%b ovf=%b exp done=1 ovf=0", tx_done, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] d;
        bit         ok;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            out_valid = 1'b1; out_data = 3'(i % 8);
            tick();
        end
        out_valid = 1'b0;
        total++; if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_full got cnt=%0d ovf=%b exp cnt=16 ovf=1", fifo_count, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            serve(2, d, ok);
            total++; if (!ok || d !== 3'(i % 8)) begin
                bad++; $display("FAIL ovf_data[%0d] got=%0d ok=%0d exp=%0d", i, d, ok, i % 8);
            end
        end
        repeat (20) tick();
        total++; if (tx_req !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_drained got req=%b cnt=%0d ovf=%b exp req=0 cnt=0 ovf=1",
                            tx_req, fifo_count, overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [2:0] exp_q [$];
        logic [2:0] d;
        bit         ok;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            out_valid = 1'b1; out_data = 3'((i * 3) % 8);
            if (i > 0) exp_q.push_back(3'((i * 3) % 8));
            tick();
        end
        out_valid = 1'b0;
        exp_q.push_back(3'd6);
        total++; if (fifo_count !== 5'd16 || tx_req !== 1'b1) begin
            bad++; $display("FAIL fullpop_pre got cnt=%0d req=%b exp cnt=16 req=1", fifo_count, tx_req);
        end
        ext_ack = 1'b1;                          // cycle M
        repeat (2) tick();                       // cycle M+2: ack_s high, pop
        out_valid = 1'b1; out_data = 3'd6;
        tick();
        out_valid = 1'b0;
        total++; if (fifo_count !== 5'd16 || overflow !== 1'b0 || tx_req !== 1'b0) begin
            bad++; $display("FAIL fullpop_same got cnt=%0d ovf=%b req=%b exp cnt=16 ovf=0 req=0",
                            fifo_count, overflow, tx_req);
        end
        ext_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            serve(1, d, ok);
            total++; if (!ok || d !== exp_q[i]) begin
                bad++; $display("FAIL fullpop_data[%0d] got=%0d ok=%0d exp=%0d", i, d, ok, exp_q[i]);
            end
        end
    endtask

    task automatic test_halt_order();
        logic [2:0] vals [3];
        logic [2:0] d;
        bit         ok;
        vals = '{3'd7, 3'd1, 3'd4};
        do_reset();
        push(vals[0]);
        push(vals[1]);
        halt_ex = 1'b1;
        push(vals[2]);
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL halt_early[%0d] got=%b exp=0", i, tx_done); end
            serve(3, d, ok);
            total++; if (!ok || d !== vals[i]) begin
                bad++; $display("FAIL halt_data[%0d] got=%0d ok=%0d exp=%0d", i, d, ok, vals[i]);
            end
        end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL halt_before_idle got=%b exp=0", tx_done); end
        wait_done();
        total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL halt_done got=%b exp=1", tx_done); end
        push(3'd2);
        repeat (2) tick();
        total++; if (fifo_count !== 5'd0 || overflow !== 1'b0 || tx_req !== 1'b0) begin
            bad++; $display("FAIL halt_ignore got cnt=%0d ovf=%b req=%b exp 0 0 0", fifo_count, overflow, tx_req);
        end
    endtask

    task automatic test_halt_same_cycle();
        logic [2:0] d;
        bit         ok;
        do_reset();
        halt_ex = 1'b1;
        push(3'd5);
        tick();
        total++; if (tx_req !== 1'b1 || tx_data !== 3'd5 || tx_done !== 1'b0) begin
            bad++; $display("FAIL halt_same got req=%b data=%0d done=%b exp req=1 data=5 done=0",
                            tx_req, tx_data, tx_done);
        end
        serve(2, d, ok);
        wait_done();
        total++; if (!ok || d !== 3'd5 || tx_done !== 1'b1) begin
            bad++; $display("FAIL halt_same_end got data=%0d ok=%0d done=%b exp data=5 done=1", d, ok, tx_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] d;
        bit         ok;
        do_reset();
        push(3'd1);
        push(3'd2);
        push(3'd4);
        push(3'd6);
        total++; if (tx_req !== 1'b1 || fifo_count !== 5'd4) begin
            bad++; $display("FAIL rstmid_pre got req=%b cnt=%0d exp req=1 cnt=4", tx_req, fifo_count);
        end
        rst = 1'b1;
        tick();
        total++; if (tx_req !== 1'b0 || fifo_count !== 5'd0 || tx_done !== 1'b0) begin
            bad++; $display("FAIL rstmid_post got req=%b cnt=%0d done=%b exp 0 0 0", tx_req, fifo_count, tx_done);
        end
        rst = 1'b0;
        push(3'd3);
        serve(2, d, ok);
        repeat (4) tick();
        total++; if (!ok || d !== 3'd3 || fifo_count !== 5'd0) begin
            bad++; $display("FAIL rstmid_resume got data=%0d ok=%0d cnt=%0d exp data=3 cnt=0", d, ok, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_halt_order();
        test_halt_same_cycle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
